// File: rtl/flash_dbg_tracer.sv
// Flash-controller event tracer: arm/trigger capture into a trace FIFO drained to ILA probe words.
// Optional build macro FLASH_DBG_TRACER_TIMESTAMP_EN puts a free-running timestamp in trace bits [127:96].
module flash_dbg_tracer #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [7:0]  TRIG_CODE = 8'h01
) (
   input  logic         v_clk0,
   input  logic         v_rst0,
   input  logic         arm,
   input  logic         ev_valid,
   input  logic [7:0]   ev_code,
   input  logic [63:0]  ev_data,
   input  logic         drain_en,
   output logic [127:0] v_debug_0,
   output logic [63:0]  v_debug_2,
   output logic         trace_valid
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [127:0]   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  fill_c;
   logic           full_c;
   logic           empty_c;
   logic [15:0]    cap_cnt;
   logic [15:0]    drop_cnt;
   logic [15:0]    seq;
   logic [31:0]    ts_field;
   logic           arm_take_c;
   logic           push_c;
   logic           pop_c;
   logic           drop_c;
   logic [127:0]   entry_c;

`ifdef FLASH_DBG_TRACER_TIMESTAMP_EN
   logic [31:0] ts;

   // Free-running cycle timestamp, wraps naturally
   always_ff @(posedge v_clk0 or posedge v_rst0) begin
      if (v_rst0) ts <= 32'd0;
      else        ts <= ts + 32'd1;
   end

   assign ts_field = ts;
`else
   assign ts_field = 32'd0;
`endif

   assign fill_c  = wr_ptr - rd_ptr;
   assign full_c  = (fill_c == PW'(DEPTH));
   assign empty_c = (wr_ptr == rd_ptr);
   assign entry_c = {ts_field, seq, ev_code, 8'h00, ev_data};

   // Next-state and per-cycle FIFO controls; arm discards the FIFO, so it also blocks a pop
   always_comb begin
      state_nxt  = state;
      arm_take_c = 1'b0;
      push_c     = 1'b0;
      drop_c     = 1'b0;
      pop_c      = drain_en && !empty_c;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nxt  = ARMED;
               arm_take_c = 1'b1;
            end
         end
         ARMED: begin
            if (ev_valid && (ev_code == TRIG_CODE)) begin
               push_c    = 1'b1;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (ev_valid) begin
               if (!full_c || pop_c) begin
                  push_c = 1'b1;
                  if (cap_cnt == 16'(DEPTH - 1)) state_nxt = DONE;
               end else begin
                  drop_c = 1'b1;
               end
            end
         end
         DONE: begin
            if (arm) begin
               state_nxt  = ARMED;
               arm_take_c = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (arm_take_c) pop_c = 1'b0;
   end

   always_ff @(posedge v_clk0 or posedge v_rst0) begin
      if (v_rst0) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cap_cnt     <= 16'd0;
         drop_cnt    <= 16'd0;
         seq         <= 16'd0;
         v_debug_0   <= 128'd0;
         v_debug_2   <= 64'd0;
         trace_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         trace_valid <= pop_c;
         v_debug_2   <= {drop_cnt, cap_cnt, seq, 1'b0, 7'(fill_c), 6'd0, state};
         if (pop_c) begin
            v_debug_0 <= mem[rd_ptr[AW-1:0]];
            rd_ptr    <= rd_ptr + PW'(1);
         end
         if (arm_take_c) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cap_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
            seq      <= 16'd0;
         end else begin
            if (push_c) begin
               wr_ptr  <= wr_ptr + PW'(1);
               cap_cnt <= cap_cnt + 16'd1;
               seq     <= seq + 16'd1;
            end
            if (drop_c && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Trace storage; contents need no reset since pointers define validity
   always_ff @(posedge v_clk0) begin
      if (push_c) mem[wr_ptr[AW-1:0]] <= entry_c;
   end

endmodule

// File: tb/tb_flash_dbg_tracer.sv
// Randomised bench for flash_dbg_tracer against a queue-based reference model.
module tb_flash_dbg_tracer;

   localparam int unsigned DEPTH = 16;
   localparam logic [7:0]  TRIG  = 8'h01;

   logic         v_clk0;
   logic         v_rst0;
   logic         arm;
   logic         ev_valid;
   logic [7:0]   ev_code;
   logic [63:0]  ev_data;
   logic         drain_en;
   logic [127:0] v_debug_0;
   logic [63:0]  v_debug_2;
   logic         trace_valid;

   int errs   = 0;
   int checks = 0;

   // reference model state
   logic [127:0] q[$];
   int           m_st;
   logic [15:0]  m_cap, m_drop, m_seq;
   logic [31:0]  m_ts;
   logic [127:0] m_dbg0;
   logic [63:0]  m_dbg2;
   logic         m_tv;

   flash_dbg_tracer #(.DEPTH(DEPTH), .TRIG_CODE(TRIG)) dut (
      .v_clk0(v_clk0), .v_rst0(v_rst0), .arm(arm), .ev_valid(ev_valid),
      .ev_code(ev_code), .ev_data(ev_data), .drain_en(drain_en),
      .v_debug_0(v_debug_0), .v_debug_2(v_debug_2), .trace_valid(trace_valid)
   );

   initial v_clk0 = 1'b0;
   always #5 v_clk0 = ~v_clk0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_st = 0; m_cap = 0; m_drop = 0; m_seq = 0; m_ts = 0;
      m_dbg0 = '0; m_dbg2 = '0; m_tv = 1'b0;
   endtask

   task automatic model_push(input logic [7:0] c, input logic [63:0] d);
      logic [31:0] t;
`ifdef FLASH_DBG_TRACER_TIMESTAMP_EN
      t = m_ts;
`else
      t = 32'd0;
`endif
      q.push_back({t, m_seq, c, 8'h00, d});
      m_seq++;
      m_cap++;
   endtask

   // One clock of the tracer rules, evaluated on the inputs present at the edge
   task automatic model_step(input logic a, input logic e, input logic [7:0] c,
                             input logic [63:0] d, input logic dr);
      bit full, pop;
      m_dbg2 = {m_drop, m_cap, m_seq, 1'b0, 7'(q.size()), 6'd0, 2'(m_st)};
      full = (q.size() == DEPTH);
      if (a && (m_st == 0 || m_st == 3)) begin
         q.delete();
         m_cap = 0; m_drop = 0; m_seq = 0; m_st = 1; m_tv = 1'b0;
      end else begin
         pop  = dr && (q.size() != 0);
         m_tv = pop;
         if (pop) m_dbg0 = q.pop_front();
         if (e && m_st == 1 && c == TRIG) begin
            model_push(c, d);
            m_st = 2;
         end else if (e && m_st == 2) begin
            if (!full || pop) begin
               model_push(c, d);
               if (m_cap == 16'(DEPTH)) m_st = 3;
            end else if (m_drop != 16'hFFFF) begin
               m_drop++;
            end
         end
      end
      m_ts++;
   endtask

   task automatic cyc(input logic a, input logic e, input logic [7:0] c,
                      input logic [63:0] d, input logic dr);
      arm = a; ev_valid = e; ev_code = c; ev_data = d; drain_en = dr;
      @(posedge v_clk0);
      model_step(a, e, c, d, dr);
      #1;
      check("trace_valid", 128'(trace_valid), 128'(m_tv));
      check("v_debug_0", v_debug_0, m_dbg0);
      check("v_debug_2", 128'(v_debug_2), 128'(m_dbg2));
      arm = 1'b0; ev_valid = 1'b0;
   endtask

   task automatic do_reset();
      v_rst0 = 1'b1;
      arm = 0; ev_valid = 0; ev_code = 0; ev_data = 0; drain_en = 0;
      #2;
      model_reset();
      check("rst_debug_0", v_debug_0, 128'd0);
      check("rst_debug_2", 128'(v_debug_2), 128'd0);
      check("rst_trace_valid", 128'(trace_valid), 128'd0);
      @(posedge v_clk0);
      @(posedge v_clk0);
      #1;
      v_rst0 = 1'b0;
   endtask

   task automatic rand_ev(input logic dr);
      cyc(1'b0, 1'b1, 8'($urandom), {$urandom, $urandom}, dr);
   endtask

   initial begin
      do_reset();

      // arm, trigger with A5 payload, three more events
      cyc(1'b1, 1'b0, 8'h00, 64'd0, 1'b0);
      cyc(1'b0, 1'b1, TRIG, 64'hA5, 1'b0);
      for (int i = 0; i < 3; i++) rand_ev(1'b0);
      cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b0);
      check("r31_state", 128'(v_debug_2[1:0]), 128'd2);
      check("r31_fill", 128'(v_debug_2[14:8]), 128'd4);
      check("r31_seq", 128'(v_debug_2[31:16]), 128'd4);

      // keep firing until 20 events total; capture stops at DEPTH
      for (int i = 0; i < 16; i++) rand_ev(1'b0);
      cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b0);
      check("r32_state", 128'(v_debug_2[1:0]), 128'd3);
      check("r32_fill", 128'(v_debug_2[14:8]), 128'd16);
      check("r32_cap", 128'(v_debug_2[47:32]), 128'd16);
      check("r32_drop", 128'(v_debug_2[63:48]), 128'd0);

      // arm wins over a coincident event in DONE; old entries are discarded
      cyc(1'b1, 1'b1, TRIG, 64'h1234, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b1);
      check("r34_state", 128'(v_debug_2[1:0]), 128'd1);
      check("r34_fill", 128'(v_debug_2[14:8]), 128'd0);
      check("r34_drop", 128'(v_debug_2[63:48]), 128'd0);
      check("r34_no_tv", 128'(trace_valid), 128'd0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b1);

      // push while popping at the last capture slot
      cyc(1'b0, 1'b1, TRIG, 64'hBEEF, 1'b0);
      for (int i = 0; i < 14; i++) rand_ev(1'b0);
      rand_ev(1'b1);
      check("r33_tv", 128'(trace_valid), 128'd1);
      cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b0);
      check("r33_fill", 128'(v_debug_2[14:8]), 128'd15);
      check("r33_state", 128'(v_debug_2[1:0]), 128'd3);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'h00, 64'd0, 1'b1);

      // reset in the middle of a capture holding 5 entries
      cyc(1'b1, 1'b0, 8'h00, 64'd0, 1'b0);
      cyc(1'b0, 1'b1, TRIG, 64'h55, 1'b0);
      for (int i = 0; i < 4; i++) rand_ev(1'b0);
      #3;
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, TRIG, 64'h77, 1'b1);
      check("r35_no_tv", 128'(trace_valid), 128'd0);
      check("r35_state", 128'(v_debug_2[1:0]), 128'd0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            logic a, e, dr;
            logic [7:0] c;
            a  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 3) == 0) ? TRIG : 8'($urandom);
            dr = ((n / 37) % 2 == 1) && ($urandom_range(0, 3) != 0);
            cyc(a, e, c, {$urandom, $urandom}, dr);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/flash_dbg_tracer.md
FLASH_DBG_TRACER -- requirements
Module: flash_dbg_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter TRIG_CODE, default 8'h01, event code that fires the trigger.
REQ-003 SHALL have port v_clk0  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port v_rst0  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port arm  input  1  single-cycle pulse; arms a new capture.
REQ-006 SHALL have port ev_valid  input  1  flash-controller event strobe.
REQ-007 SHALL have port ev_code  input  8  event type.
REQ-008 SHALL have port ev_data  input  64  event payload.
REQ-009 SHALL have port drain_en  input  1  level; permits FIFO readout.
REQ-010 SHALL have port v_debug_0  output  128  registered trace word, ILA probe0 source.
REQ-011 SHALL have port v_debug_2  output  64  registered status word, ILA probe2 source.
REQ-012 SHALL have port trace_valid  output  1  high for the cycle a new trace word is presented.

Function
REQ-013 SHALL implement states IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-014 SHALL move IDLE or DONE -> ARMED on arm, emptying the FIFO and clearing capture and drop counts that cycle.
REQ-015 SHALL ignore arm while in ARMED or CAPTURE.
REQ-016 SHALL move ARMED -> CAPTURE on ev_valid with ev_code==TRIG_CODE, and write that triggering event as the first entry.
REQ-017 SHALL in CAPTURE write each ev_valid event; an event is accepted if FIFO not full, or full with a pop in the same cycle.
REQ-018 SHALL move CAPTURE -> DONE in the cycle the capture count reaches DEPTH; later events are not written.
REQ-019 SHALL, when an event arrives in CAPTURE and cannot be accepted, drop it and increment the 16-bit drop count, saturating at 16'hFFFF.
REQ-020 SHALL form each entry as [127:96] timestamp, [95:80] sequence, [79:72] ev_code, [71:64] zero, [63:0] ev_data.
REQ-021 SHALL keep a 32-bit free-running timestamp counter, +1 every cycle, wrapping 32'hFFFFFFFF -> 0.
REQ-022 SHALL keep a 16-bit sequence counter, +1 per accepted entry, wrapping to 0, reset to 0 on arm.
REQ-023 SHALL pop one entry per cycle while drain_en=1 and FIFO non-empty, in any state.
REQ-024 SHALL present a popped entry on v_debug_0 the cycle after the pop with trace_valid=1; v_debug_0 holds its last value otherwise.
REQ-025 SHALL drive v_debug_2 as [63:48] drop count, [47:32] capture count, [31:16] sequence, [14:8] fill level, [1:0] state, others zero, registered one cycle.
REQ-026 SHALL give arm priority over a coincident event in DONE; that event is neither written nor counted.
REQ-027 SHALL, on arm, discard unpopped entries; no trace_valid for discarded entries.

Reset
REQ-028 SHALL on v_rst0 clear state to IDLE, FIFO pointers, all counters, v_debug_0, v_debug_2 and trace_valid to zero, regardless of phase.
REQ-029 SHALL resume normal operation the first clock edge after v_rst0 deasserts; a mid-capture reset requires a new arm.

Configuration
REQ-030 SHALL honour macro FLASH_DBG_TRACER_TIMESTAMP_EN: defined, [127:96] carries the timestamp; undefined, the counter is removed and [127:96] reads zero.

Verification
REQ-031 SHALL verify reset then arm, event code 8'h01 data 64'hA5, 3 further events -> 4 entries, sequence 0..3, state CAPTURE.
REQ-032 SHALL verify DEPTH=16 with 20 events, drain_en=0 -> state DONE after 16th, drop count 0, 4 events ignored, fill 16.
REQ-033 SHALL verify full FIFO with drain_en=1 and ev_valid same cycle in CAPTURE -> event accepted, fill unchanged, trace_valid next cycle.
REQ-034 SHALL verify arm and event in same DONE cycle -> state ARMED, fill 0, drop count 0, no entry.
REQ-035 SHALL verify v_rst0 asserted mid-capture with 5 entries -> all outputs 0, state IDLE immediately, no trace_valid after release.
